queue_dut: RTL and testbench
============================

Name: queue_dut

Overview:
- Circular FIFO test target, placed directly downstream of the board test/console unit on the lab1 board.
- Consumes that unit's address bus, write data, one-cycle write enable and debounced step level.
- Returns 32-bit read data for seven-segment display.
- Pushes entered values, pops one entry per step press, and exposes contents and status through the address window.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..16.
- DATA_W, 32, entry width.
- ADDR_W, 16, width of the address bus.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous active-high reset; one clock; all state is sampled on the clk rising edge.
- we  input  1  push strobe; one-cycle pulse.
- din  input  DATA_W  push data.
- addr  input  ADDR_W  view/status select.
- step_stable  input  1  debounced step button level; the pop source.
- dout  output  DATA_W  registered view data; drives the display data input upstream.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - head, tail and count cleared to 0.
  - last_pop cleared to 0.
  - step_d register cleared to 0.
  - dout = 0, empty = 1, full = 0.
  - Entry storage is not cleared.
  - Reset during a push or pop cycle wins; that operation is discarded.
- Pop pulse:
  - pop_p = step_stable & ~step_d; step_d <= step_stable every cycle.
  - A held button therefore pops exactly once.
  - Release of the button never pops.
- Push accepted = we & (~full | pop_ok).
- Pop accepted = pop_ok = pop_p & ~empty.
- Single operations:
  - Push: mem[tail] <= din; tail <= tail+1 (mod DEPTH); count+1.
  - Pop: last_pop <= mem[head]; head <= head+1 (mod DEPTH); count-1.
- Simultaneous push and pop:
  - Not empty: both performed; count unchanged.
  - Full: both performed; the pushed word lands in the slot freed this cycle; count stays DEPTH.
  - Empty: push only; pop ignored.
- Rejected operations:
  - Push when full without a pop: dropped; no state change.
  - Pop when empty: ignored; last_pop is retained.
- Pointer wrap: head and tail wrap DEPTH-1 -> 0 with no bubble.
- Read window (dout registered, 1-cycle latency from addr or state change):
  - addr[ADDR_W-1:12] == 0: entry at offset k = addr[$clog2(DEPTH)-1:0] from head, i.e. mem[(head+k) mod DEPTH]. If k >= count, reads 0. Address bits [11:$clog2(DEPTH)] are ignored.
  - addr == 16'hF000: status word {zero-fill, count[15:8 field], full at bit 1, empty at bit 0}. Exact packing: bits[15:8] = count zero-extended, bit1 = full, bit0 = empty, all other bits 0.
  - addr == 16'hF001: last_pop.
  - addr == 16'hF002: error counter word (see Optional Feature).
  - Any other address: 0.
- Registered-output timing: dout reflects state as of the previous edge. A push at edge N is visible at offset count-1 on dout after edge N+1.
- full, empty and count are combinational from the count register, so there is no extra latency.

Optional Feature:
- Macro: QUEUE_DUT_ERR_CNT_EN.
- Defined:
  - Two 16-bit saturating counters: ovf_cnt (rejected pushes) and udf_cnt (pops on empty).
  - Both cleared on rst; each saturates at 16'hFFFF.
  - Address F002 reads {ovf_cnt, udf_cnt}.
- Not defined:
  - No counters are synthesized.
  - F002 reads 0.

Decomposition:
- Package queue_dut_pkg holds:
  - Defaults for DEPTH and DATA_W.
  - Address constants ADDR_STATUS = 16'hF000, ADDR_LASTPOP = 16'hF001, ADDR_ERRCNT = 16'hF002.
  - Window-select mask 16'hF000.
- One natural sub-module: edge_rise_pulse (registered rising-edge detector with synchronous reset), used for pop_p.
- The FIFO core and read mux stay in queue_dut.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33 -> count=3, empty=0. addr 0/1/2 read 0x11/0x22/0x33 one cycle later; addr 3 reads 0.
2. Fill to 8 entries 0xA0..0xA7, then push 0xFF -> full=1, count=8, entry 7 remains 0xA7. With the feature enabled, F002 reads 0x0001_0000.
3. From full, assert we with din=0xBB in the same cycle as a step rising edge -> last_pop=0xA0, count=8, offset 7 reads 0xBB, head advanced.
4. Hold step_stable high for 50 cycles on a queue holding 2 entries -> exactly one pop (count 2->1). Release -> no pop.
5. On an empty queue, press step -> count stays 0, last_pop unchanged. With the feature enabled, F002 reads 0x0000_0001. Push 0x5 and pop in the same cycle on empty -> count=1, offset 0 reads 0x5.
6. Push 9 times and pop 9 times alternating so head and tail wrap -> values are read back in order, F000 reads 0x0000_0001 at end. Assert rst mid-sequence -> next cycle count=0, empty=1, dout=0.

Source files
------------

// File: rtl/queue_dut_pkg.sv
// -----------------------------------------------------------------------------
// queue_dut_pkg
// Shared constants and helpers for the queue_dut FIFO test target.
//   - Default sizing for DEPTH / DATA_W / ADDR_W.
//   - Address-window constants for the status, last-pop and error-counter words.
//   - pack_status(): builds the status word read at ADDR_STATUS.
//   - sat_inc16(): 16-bit saturating increment for the optional error counters.
// -----------------------------------------------------------------------------
package queue_dut_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 16;

    localparam logic [15:0] ADDR_STATUS  = 16'hF000;
    localparam logic [15:0] ADDR_LASTPOP = 16'hF001;
    localparam logic [15:0] ADDR_ERRCNT  = 16'hF002;

    // Bits that must be zero for an address to hit the entry window.
    localparam logic [15:0] WIN_MASK     = 16'hF000;

    // Status word: bits[15:8] occupancy, bit1 full, bit0 empty, rest zero.
    function automatic logic [31:0] pack_status(input logic [7:0] cnt,
                                                input logic       is_full,
                                                input logic       is_empty);
        return {16'h0000, cnt, 6'b000000, is_full, is_empty};
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'h0001);
    endfunction

endpackage : queue_dut_pkg

// File: rtl/queue_dut_if.sv
// -----------------------------------------------------------------------------
// queue_dut_if
// Bundle between the board test/console unit (master) and the FIFO (slave).
//   we          push strobe, one-cycle pulse          (master -> slave)
//   din         push data                             (master -> slave)
//   addr        view/status select                    (master -> slave)
//   step_stable debounced step button level (pops)    (master -> slave)
//   dout        registered view data                  (slave  -> master)
//   full        occupancy == DEPTH                    (slave  -> master)
//   empty       occupancy == 0                        (slave  -> master)
//   count       current occupancy                     (slave  -> master)
// -----------------------------------------------------------------------------
interface queue_dut_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              we;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] addr;
    logic              step_stable;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport master (
        output we, din, addr, step_stable,
        input  dout, full, empty, count
    );

    modport slave (
        input  we, din, addr, step_stable,
        output dout, full, empty, count
    );

endinterface : queue_dut_if

// File: rtl/queue_dut_edge_rise_pulse.sv
// -----------------------------------------------------------------------------
// edge_rise_pulse
// Rising-edge detector on an already-debounced level. The previous level is
// held in a flop; the pulse is high for the single cycle where the level is
// high and the flop still holds low, so a held level yields one pulse and a
// falling level yields none.
//   clk    system clock
//   rst    synchronous active-high reset (clears the history flop)
//   level  input level
//   pulse  one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module edge_rise_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;
    logic level_d;

    // Next history value and edge pulse.
    always_comb begin
        level_d = level;
        pulse   = level & ~level_q;
    end

    // History flop, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

endmodule : edge_rise_pulse

// File: rtl/queue_dut.sv
// -----------------------------------------------------------------------------
// queue_dut
// Circular FIFO placed downstream of the board test/console unit. Values are
// pushed with a one-cycle write strobe, one entry is popped per step-button
// press, and contents/status are exposed through an address window on a
// registered 32-bit read port for the seven-segment display.
//
// Ports:
//   clk   system clock (100 MHz)
//   rst   synchronous active-high reset
//   bus   queue_dut_if.slave: we, din, addr, step_stable in;
//         dout, full, empty, count out
//
// Read window (dout, one cycle after addr/state):
//   addr[15:12]==0 : entry at offset addr[log2(DEPTH)-1:0] from head, 0 past count
//   16'hF000       : status {count in [15:8], full [1], empty [0]}
//   16'hF001       : last popped value
//   16'hF002       : {ovf_cnt, udf_cnt} when built with QUEUE_DUT_ERR_CNT_EN,
//                    otherwise 0
//   other          : 0
//
// Build option: define QUEUE_DUT_ERR_CNT_EN to add 16-bit saturating counters
// of rejected pushes (ovf_cnt) and pops on empty (udf_cnt).
// -----------------------------------------------------------------------------
module queue_dut
    import queue_dut_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    queue_dut_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage and state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q,     head_d;
    logic [PTR_W-1:0]  tail_q,     tail_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [DATA_W-1:0] last_pop_q, last_pop_d;
    logic [DATA_W-1:0] dout_q,     dout_d;

    // Control
    logic              pop_p_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_ok_s;
    logic              push_ok_s;

    // Read path
    logic [PTR_W-1:0]  k_s;
    logic [PTR_W-1:0]  rd_idx_s;
    logic              win_sel_s;
    logic [31:0]       err_word_s;

    edge_rise_pulse u_step_edge (
        .clk   (clk),
        .rst   (rst),
        .level (bus.step_stable),
        .pulse (pop_p_s)
    );

    // Status flags and operation acceptance.
    always_comb begin
        full_s    = (count_q == CNT_W'(DEPTH));
        empty_s   = (count_q == {CNT_W{1'b0}});
        pop_ok_s  = pop_p_s & ~empty_s;
        // A pop in the same cycle frees a slot, so a full queue still accepts.
        push_ok_s = bus.we & (~full_s | pop_ok_s);
    end

    // Next-state for pointers, occupancy and last popped value.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        last_pop_d = last_pop_q;

        if (pop_ok_s) begin
            head_d     = head_q + PTR_W'(1);
            last_pop_d = mem_q[head_q];
        end else begin
            head_d     = head_q;
            last_pop_d = last_pop_q;
        end

        if (push_ok_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef QUEUE_DUT_ERR_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic [15:0] udf_cnt_q, udf_cnt_d;

    // Error counter next-state: rejected pushes and pop presses on empty.
    always_comb begin
        ovf_cnt_d  = ovf_cnt_q;
        udf_cnt_d  = udf_cnt_q;
        err_word_s = {ovf_cnt_q, udf_cnt_q};
        if (bus.we && !push_ok_s) begin
            ovf_cnt_d = sat_inc16(ovf_cnt_q);
        end else begin
            ovf_cnt_d = ovf_cnt_q;
        end
        if (pop_p_s && empty_s) begin
            udf_cnt_d = sat_inc16(udf_cnt_q);
        end else begin
            udf_cnt_d = udf_cnt_q;
        end
    end

    // Error counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= 16'h0000;
            udf_cnt_q <= 16'h0000;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end
`else
    // Without the counters the error word reads as zero.
    always_comb begin
        err_word_s = 32'h0000_0000;
    end
`endif

    // Address decode and read mux feeding the registered display port.
    always_comb begin
        k_s       = bus.addr[PTR_W-1:0];
        rd_idx_s  = head_q + k_s;   // wraps modulo DEPTH by width
        win_sel_s = ((bus.addr & ADDR_W'(WIN_MASK)) == {ADDR_W{1'b0}});
        dout_d    = {DATA_W{1'b0}};

        if (win_sel_s) begin
            // Offsets at or beyond the occupancy show as zero, not stale data.
            if ({1'b0, k_s} < count_q) begin
                dout_d = mem_q[rd_idx_s];
            end else begin
                dout_d = {DATA_W{1'b0}};
            end
        end else if (bus.addr == ADDR_W'(ADDR_STATUS)) begin
            dout_d = DATA_W'(pack_status(8'(count_q), full_s, empty_s));
        end else if (bus.addr == ADDR_W'(ADDR_LASTPOP)) begin
            dout_d = last_pop_q;
        end else if (bus.addr == ADDR_W'(ADDR_ERRCNT)) begin
            dout_d = DATA_W'(err_word_s);
        end else begin
            dout_d = {DATA_W{1'b0}};
        end
    end

    // Control/state registers; reset wins over any operation in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            last_pop_q <= {DATA_W{1'b0}};
            dout_q     <= {DATA_W{1'b0}};
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            last_pop_q <= last_pop_d;
            dout_q     <= dout_d;
        end
    end

    // Entry storage: not reset; a write during reset is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            mem_q[tail_q] <= bus.din;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.full  = full_s;
    assign bus.empty = empty_s;
    assign bus.count = count_q;

endmodule : queue_dut

// File: tb/tb_queue_dut.sv
// -----------------------------------------------------------------------------
// tb_queue_dut
// Directed self-checking bench for queue_dut (DEPTH=8, DATA_W=32, ADDR_W=16).
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_queue_dut;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

`ifdef QUEUE_DUT_ERR_CNT_EN
    localparam logic [31:0] EXP_ERR_OVF1 = 32'h0001_0000;
    localparam logic [31:0] EXP_ERR_UDF1 = 32'h0000_0001;
`else
    localparam logic [31:0] EXP_ERR_OVF1 = 32'h0000_0000;
    localparam logic [31:0] EXP_ERR_UDF1 = 32'h0000_0000;
`endif

    queue_dut_if #(.DEPTH(8), .DATA_W(32), .ADDR_W(16)) qif ();

    queue_dut #(.DEPTH(8), .DATA_W(32), .ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (qif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        qif.we  = 1'b1;
        qif.din = v;
        tick();
        qif.we  = 1'b0;
    endtask

    task automatic press();
        qif.step_stable = 1'b1;
        tick();
        qif.step_stable = 1'b0;
        tick();
    endtask

    task automatic read_at(input logic [15:0] a);
        qif.addr = a;
        tick();
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        qif.we          = 1'b0;
        qif.step_stable = 1'b0;
        tick();
        rst             = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if (qif.count !== 4'd0 || qif.empty !== 1'b1 || qif.full !== 1'b0 || qif.dout !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_state: got count=%0d empty=%b full=%b dout=%h expected 0/1/0/0",
                     qif.count, qif.empty, qif.full, qif.dout);
        end
    endtask

    task automatic test_push_read();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33; exp_v[3] = 32'h0;
        push(32'h11);
        push(32'h22);
        push(32'h33);
        vec_cnt++;
        if (qif.count !== 4'd3 || qif.empty !== 1'b0) begin
            err_cnt++;
            $display("FAIL push3_status: got count=%0d empty=%b expected 3/0", qif.count, qif.empty);
        end
        for (int i = 0; i < 4; i++) begin
            read_at(16'(i));
            vec_cnt++;
            if (qif.dout !== exp_v[i]) begin
                err_cnt++;
                $display("FAIL push3_read%0d: got %h expected %h", i, qif.dout, exp_v[i]);
            end
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
        push(32'hFF);
        vec_cnt++;
        if (qif.full !== 1'b1 || qif.count !== 4'd8) begin
            err_cnt++;
            $display("FAIL fill_status: got full=%b count=%0d expected 1/8", qif.full, qif.count);
        end
        read_at(16'h0007);
        vec_cnt++;
        if (qif.dout !== 32'hA7) begin
            err_cnt++;
            $display("FAIL fill_entry7: got %h expected %h", qif.dout, 32'hA7);
        end
        read_at(16'h0000);
        vec_cnt++;
        if (qif.dout !== 32'hA0) begin
            err_cnt++;
            $display("FAIL fill_entry0: got %h expected %h", qif.dout, 32'hA0);
        end
        read_at(16'hF000);
        vec_cnt++;
        if (qif.dout !== 32'h0000_0802) begin
            err_cnt++;
            $display("FAIL fill_statusword: got %h expected %h", qif.dout, 32'h0000_0802);
        end
        read_at(16'hF002);
        vec_cnt++;
        if (qif.dout !== EXP_ERR_OVF1) begin
            err_cnt++;
            $display("FAIL fill_errcnt: got %h expected %h", qif.dout, EXP_ERR_OVF1);
        end
    endtask

    task automatic test_full_push_pop();
        qif.we          = 1'b1;
        qif.din         = 32'hBB;
        qif.step_stable = 1'b1;
        tick();
        qif.we          = 1'b0;
        qif.step_stable = 1'b0;
        tick();
        vec_cnt++;
        if (qif.count !== 4'd8 || qif.full !== 1'b1) begin
            err_cnt++;
            $display("FAIL fullpp_count: got count=%0d full=%b expected 8/1", qif.count, qif.full);
        end
        read_at(16'hF001);
        vec_cnt++;
        if (qif.dout !== 32'hA0) begin
            err_cnt++;
            $display("FAIL fullpp_lastpop: got %h expected %h", qif.dout, 32'hA0);
        end
        read_at(16'h0007);
        vec_cnt++;
        if (qif.dout !== 32'hBB) begin
            err_cnt++;
            $display("FAIL fullpp_entry7: got %h expected %h", qif.dout, 32'hBB);
        end
        // Bits 11:3 are ignored inside the window: 0x0FF8 is offset 0.
        read_at(16'h0FF8);
        vec_cnt++;
        if (qif.dout !== 32'hA1) begin
            err_cnt++;
            $display("FAIL fullpp_head: got %h expected %h", qif.dout, 32'hA1);
        end
    endtask

    task automatic test_held_step();
        do_reset();
        push(32'h41);
        push(32'h42);
        qif.step_stable = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        vec_cnt++;
        if (qif.count !== 4'd1) begin
            err_cnt++;
            $display("FAIL held_count: got %0d expected %0d", qif.count, 1);
        end
        qif.step_stable = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        vec_cnt++;
        if (qif.count !== 4'd1) begin
            err_cnt++;
            $display("FAIL release_count: got %0d expected %0d", qif.count, 1);
        end
        read_at(16'h0000);
        vec_cnt++;
        if (qif.dout !== 32'h42) begin
            err_cnt++;
            $display("FAIL held_entry0: got %h expected %h", qif.dout, 32'h42);
        end
    endtask

    task automatic test_empty_pop();
        press();
        vec_cnt++;
        if (qif.count !== 4'd0 || qif.empty !== 1'b1) begin
            err_cnt++;
            $display("FAIL drain_count: got count=%0d empty=%b expected 0/1", qif.count, qif.empty);
        end
        press();
        vec_cnt++;
        if (qif.count !== 4'd0) begin
            err_cnt++;
            $display("FAIL emptypop_count: got %0d expected %0d", qif.count, 0);
        end
        read_at(16'hF001);
        vec_cnt++;
        if (qif.dout !== 32'h42) begin
            err_cnt++;
            $display("FAIL emptypop_lastpop: got %h expected %h", qif.dout, 32'h42);
        end
        read_at(16'hF002);
        vec_cnt++;
        if (qif.dout !== EXP_ERR_UDF1) begin
            err_cnt++;
            $display("FAIL emptypop_errcnt: got %h expected %h", qif.dout, EXP_ERR_UDF1);
        end
        qif.we          = 1'b1;
        qif.din         = 32'h5;
        qif.step_stable = 1'b1;
        tick();
        qif.we          = 1'b0;
        qif.step_stable = 1'b0;
        tick();
        vec_cnt++;
        if (qif.count !== 4'd1) begin
            err_cnt++;
            $display("FAIL emptypp_count: got %0d expected %0d", qif.count, 1);
        end
        read_at(16'h0000);
        vec_cnt++;
        if (qif.dout !== 32'h5) begin
            err_cnt++;
            $display("FAIL emptypp_entry0: got %h expected %h", qif.dout, 32'h5);
        end
        read_at(16'h1234);
        vec_cnt++;
        if (qif.dout !== 32'h0) begin
            err_cnt++;
            $display("FAIL unmapped_addr: got %h expected %h", qif.dout, 32'h0);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] v;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            v = 32'h100 + 32'(i);
            push(v);
            read_at(16'h0000);
            vec_cnt++;
            if (qif.dout !== v) begin
                err_cnt++;
                $display("FAIL wrap_head%0d: got %h expected %h", i, qif.dout, v);
            end
            press();
            read_at(16'hF001);
            vec_cnt++;
            if (qif.dout !== v) begin
                err_cnt++;
                $display("FAIL wrap_pop%0d: got %h expected %h", i, qif.dout, v);
            end
        end
        read_at(16'hF000);
        vec_cnt++;
        if (qif.dout !== 32'h0000_0001) begin
            err_cnt++;
            $display("FAIL wrap_status: got %h expected %h", qif.dout, 32'h0000_0001);
        end
        push(32'h77);
        push(32'h78);
        qif.addr = 16'h0000;
        rst      = 1'b1;
        qif.we   = 1'b1;
        qif.din  = 32'h79;
        tick();
        rst      = 1'b0;
        qif.we   = 1'b0;
        vec_cnt++;
        if (qif.count !== 4'd0 || qif.empty !== 1'b1 || qif.dout !== 32'h0) begin
            err_cnt++;
            $display("FAIL midrst_state: got count=%0d empty=%b dout=%h expected 0/1/0",
                     qif.count, qif.empty, qif.dout);
        end
        tick();
        vec_cnt++;
        if (qif.count !== 4'd0 || qif.dout !== 32'h0) begin
            err_cnt++;
            $display("FAIL midrst_after: got count=%0d dout=%h expected 0/0", qif.count, qif.dout);
        end
    endtask

    initial begin
        vec_cnt         = 0;
        err_cnt         = 0;
        rst             = 1'b0;
        qif.we          = 1'b0;
        qif.din         = 32'h0;
        qif.addr        = 16'h0;
        qif.step_stable = 1'b0;
        tick();
        test_reset();
        test_push_read();
        test_fill_overflow();
        test_full_push_pop();
        test_held_step();
        test_empty_pop();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_queue_dut
